// File: rtl/mine_logic.sv
// mine_logic: 8x8 minesweeper game-state engine (cursor, flag map, reveal map, win/loss).
// Flood reveal of zero-count regions is compiled in when MINE_LOGIC_FLOOD_FILL_EN is defined.
module mine_logic (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mine_map,
    input  logic        load,
    input  logic        step,
    input  logic        flag,
    input  logic        mv_up,
    input  logic        mv_down,
    input  logic        mv_left,
    input  logic        mv_right,
    output logic [63:0] mine_map_q,
    output logic [63:0] flag_map,
    output logic [63:0] step_map,
    output logic [5:0]  cursor,
    output logic        busy,
    output logic        game_over,
    output logic        game_won
);
    localparam int unsigned CELLS = 64;
    localparam int unsigned DIM   = 8;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned RC_W  = 3;
    localparam int unsigned CNT_W = 4;

`ifdef MINE_LOGIC_FLOOD_FILL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LOST = 2'd2,
        WON  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOST = 2'd2,
        WON  = 2'd3
    } state_t;
`endif

    state_t           state, state_nxt;
    logic [CELLS-1:0] mine_nxt, flag_nxt, step_nxt;
    logic [IDX_W-1:0] cursor_nxt;
    logic             over_nxt, won_nxt;
    logic [RC_W-1:0]  cur_row, cur_col;

    assign cur_row = cursor[5:3];
    assign cur_col = cursor[2:0];

`ifdef MINE_LOGIC_FLOOD_FILL_EN
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             changed, changed_nxt;
    logic             busy_nxt;
    logic [CELLS-1:0] zero_map;
    logic             scan_reveal_c;

    // Mask of the up-to-8 in-bounds neighbours of a cell.
    function automatic logic [CELLS-1:0] nbr_mask(input logic [IDX_W-1:0] cell);
        logic [CELLS-1:0] m;
        int r;
        int c;
        m = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(cell[5:3]) + dr;
                c = int'(cell[2:0]) + dc;
                if ((dr != 0 || dc != 0) && r >= 0 && r < int'(DIM) && c >= 0 && c < int'(DIM))
                    m[IDX_W'(r * int'(DIM) + c)] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [CELLS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(CELLS); i++)
            n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // Cells whose neighbour count is zero.
    always_comb begin
        zero_map = '0;
        for (int i = 0; i < int'(CELLS); i++)
            zero_map[i] = (popcount(mine_map_q & nbr_mask(IDX_W'(i))) == '0);
    end

    // Scan cell reveal: closed, unflagged, safe, next to an open zero-count cell.
    always_comb begin
        scan_reveal_c = !step_map[idx] && !flag_map[idx] && !mine_map_q[idx]
                        && (|(step_map & zero_map & nbr_mask(idx)));
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        mine_nxt   = mine_map_q;
        flag_nxt   = flag_map;
        step_nxt   = step_map;
        cursor_nxt = cursor;
        over_nxt   = game_over;
        won_nxt    = game_won;
`ifdef MINE_LOGIC_FLOOD_FILL_EN
        idx_nxt     = idx;
        changed_nxt = changed;
`endif
        if (load) begin
            state_nxt  = IDLE;
            mine_nxt   = mine_map;
            flag_nxt   = '0;
            step_nxt   = '0;
            cursor_nxt = '0;
            over_nxt   = 1'b0;
            won_nxt    = 1'b0;
`ifdef MINE_LOGIC_FLOOD_FILL_EN
            idx_nxt     = '0;
            changed_nxt = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!game_over && !game_won) begin
                        if (&(step_map | mine_map_q)) begin
                            won_nxt   = 1'b1;
                            state_nxt = WON;
                        end else if (step) begin
                            if (!flag_map[cursor] && !step_map[cursor]) begin
                                step_nxt[cursor] = 1'b1;
                                if (mine_map_q[cursor]) begin
                                    over_nxt  = 1'b1;
                                    state_nxt = LOST;
                                end
`ifdef MINE_LOGIC_FLOOD_FILL_EN
                                else if (zero_map[cursor]) begin
                                    state_nxt   = SCAN;
                                    idx_nxt     = '0;
                                    changed_nxt = 1'b0;
                                end
`endif
                            end
                        end else if (flag) begin
                            if (!step_map[cursor])
                                flag_nxt[cursor] = !flag_map[cursor];
                        end else if (mv_up) begin
                            if (cur_row != '0)
                                cursor_nxt = {cur_row - RC_W'(1), cur_col};
                        end else if (mv_down) begin
                            if (cur_row != RC_W'(DIM - 1))
                                cursor_nxt = {cur_row + RC_W'(1), cur_col};
                        end else if (mv_left) begin
                            if (cur_col != '0)
                                cursor_nxt = {cur_row, cur_col - RC_W'(1)};
                        end else if (mv_right) begin
                            if (cur_col != RC_W'(DIM - 1))
                                cursor_nxt = {cur_row, cur_col + RC_W'(1)};
                        end
                    end
                end
`ifdef MINE_LOGIC_FLOOD_FILL_EN
                SCAN: begin
                    if (scan_reveal_c)
                        step_nxt[idx] = 1'b1;
                    // A reveal at the last index still counts toward another pass.
                    if (idx == IDX_W'(CELLS - 1)) begin
                        if (changed || scan_reveal_c) begin
                            idx_nxt     = '0;
                            changed_nxt = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt     = idx + IDX_W'(1);
                        changed_nxt = changed || scan_reveal_c;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef MINE_LOGIC_FLOOD_FILL_EN
    assign busy_nxt = (state_nxt == SCAN);
`else
    assign busy = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mine_map_q <= '0;
            flag_map   <= '0;
            step_map   <= '0;
            cursor     <= '0;
            game_over  <= 1'b0;
            game_won   <= 1'b0;
`ifdef MINE_LOGIC_FLOOD_FILL_EN
            idx        <= '0;
            changed    <= 1'b0;
            busy       <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            mine_map_q <= mine_nxt;
            flag_map   <= flag_nxt;
            step_map   <= step_nxt;
            cursor     <= cursor_nxt;
            game_over  <= over_nxt;
            game_won   <= won_nxt;
`ifdef MINE_LOGIC_FLOOD_FILL_EN
            idx        <= idx_nxt;
            changed    <= changed_nxt;
            busy       <= busy_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mine_logic.sv
// Self-checking bench for mine_logic: directed scenarios plus random play against a board-level model.
module tb_mine_logic;
    logic        clk;
    logic        reset;
    logic [63:0] mine_map;
    logic        load, step, flag, mv_up, mv_down, mv_left, mv_right;
    logic [63:0] mine_map_q, flag_map, step_map;
    logic [5:0]  cursor;
    logic        busy, game_over, game_won;

    mine_logic dut (
        .clk        (clk),
        .reset      (reset),
        .mine_map   (mine_map),
        .load       (load),
        .step       (step),
        .flag       (flag),
        .mv_up      (mv_up),
        .mv_down    (mv_down),
        .mv_left    (mv_left),
        .mv_right   (mv_right),
        .mine_map_q (mine_map_q),
        .flag_map   (flag_map),
        .step_map   (step_map),
        .cursor     (cursor),
        .busy       (busy),
        .game_over  (game_over),
        .game_won   (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] C_LOAD  = 7'b1000000;
    localparam logic [6:0] C_STEP  = 7'b0100000;
    localparam logic [6:0] C_FLAG  = 7'b0010000;
    localparam logic [6:0] C_UP    = 7'b0001000;
    localparam logic [6:0] C_DOWN  = 7'b0000100;
    localparam logic [6:0] C_LEFT  = 7'b0000010;
    localparam logic [6:0] C_RIGHT = 7'b0000001;

    int n_vec = 0;
    int n_err = 0;

    // Board model
    bit [63:0] m_mine, m_flag, m_step;
    int        m_row, m_col, m_passes;
    bit        m_over, m_won;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int mines_around(input int r, input int c);
        int n = 0;
        for (int rr = r - 1; rr <= r + 1; rr++)
            for (int cc = c - 1; cc <= c + 1; cc++)
                if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && !(rr == r && cc == c))
                    n += int'(m_mine[rr * 8 + cc]);
        return n;
    endfunction

    function automatic bit touches_open_zero(input int r, input int c);
        for (int rr = r - 1; rr <= r + 1; rr++)
            for (int cc = c - 1; cc <= c + 1; cc++)
                if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && !(rr == r && cc == c))
                    if (m_step[rr * 8 + cc] && mines_around(rr, cc) == 0)
                        return 1'b1;
        return 1'b0;
    endfunction

    // Raster passes until one pass opens nothing.
    task automatic model_flood();
        bit ch;
        m_passes = 0;
        do begin
            ch = 1'b0;
            for (int i = 0; i < 64; i++)
                if (!m_step[i] && !m_flag[i] && !m_mine[i] && touches_open_zero(i / 8, i % 8)) begin
                    m_step[i] = 1'b1;
                    ch = 1'b1;
                end
            m_passes++;
        end while (ch);
    endtask

    task automatic model_apply(input logic [6:0] cmd, input logic [63:0] mm);
        int i;
        m_passes = 0;
        i = m_row * 8 + m_col;
        if (cmd[6]) begin
            m_mine = mm; m_flag = '0; m_step = '0;
            m_row = 0; m_col = 0; m_over = 1'b0; m_won = 1'b0;
        end else if (!m_over && !m_won) begin
            if (cmd[5]) begin
                if (!m_flag[i] && !m_step[i]) begin
                    m_step[i] = 1'b1;
                    if (m_mine[i]) m_over = 1'b1;
                    else if (mines_around(m_row, m_col) == 0) begin
`ifdef MINE_LOGIC_FLOOD_FILL_EN
                        model_flood();
`endif
                    end
                end
            end else if (cmd[4]) begin
                if (!m_step[i]) m_flag[i] = !m_flag[i];
            end else if (cmd[3]) begin
                if (m_row > 0) m_row--;
            end else if (cmd[2]) begin
                if (m_row < 7) m_row++;
            end else if (cmd[1]) begin
                if (m_col > 0) m_col--;
            end else if (cmd[0]) begin
                if (m_col < 7) m_col++;
            end
        end
        if (!m_over && !m_won && (&(m_step | m_mine))) m_won = 1'b1;
    endtask

    task automatic drive(input logic [6:0] cmd, input logic [63:0] mm);
        @(negedge clk);
        {load, step, flag, mv_up, mv_down, mv_left, mv_right} = cmd;
        mine_map = mm;
        @(negedge clk);
        {load, step, flag, mv_up, mv_down, mv_left, mv_right} = 7'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":mine_map_q"}, mine_map_q, m_mine);
        check({tag, ":flag_map"}, flag_map, m_flag);
        check({tag, ":step_map"}, step_map, m_step);
        check({tag, ":cursor"}, 64'(cursor), 64'(m_row * 8 + m_col));
        check({tag, ":busy"}, 64'(busy), 64'(0));
        check({tag, ":game_over"}, 64'(game_over), 64'(m_over));
        check({tag, ":game_won"}, 64'(game_won), 64'(m_won));
    endtask

    // Count busy cycles, then allow one cycle for the win check.
    task automatic settle_and_check(input string tag);
        int cyc = 0;
        while (busy === 1'b1 && cyc < 4096) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, ":busy_len"}, 64'(cyc), 64'(m_passes * 64));
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_cmd(input logic [6:0] cmd, input logic [63:0] mm, input string tag);
        drive(cmd, mm);
        model_apply(cmd, mm);
        settle_and_check(tag);
    endtask

    function automatic logic [63:0] rand_map();
        logic [63:0] a, b, c, d;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c = {$urandom, $urandom}; d = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return a & b & c;
            1:       return a & b;
            2:       return ~(a & b & c);
            default: return a & b & c & d;
        endcase
    endfunction

    initial begin
        int cyc;
        logic [6:0] cmd;
        reset = 1'b1;
        mine_map = '0;
        {load, step, flag, mv_up, mv_down, mv_left, mv_right} = 7'b0;
        m_mine = '0; m_flag = '0; m_step = '0;
        m_row = 0; m_col = 0; m_over = 1'b0; m_won = 1'b0; m_passes = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all("reset");
        reset = 1'b0;

        // Moves, edge clamp and flag toggling
        do_cmd(C_LOAD, 64'h1, "mv_load");
        do_cmd(C_RIGHT, '0, "mv_right");
        do_cmd(C_DOWN, '0, "mv_down");
        do_cmd(C_LEFT, '0, "mv_left");
        do_cmd(C_LEFT, '0, "mv_left_clamp");
        check("cursor_o10", 64'(cursor), 64'(6'o10));
        do_cmd(C_FLAG, '0, "flag_set");
        check("flag_100", flag_map, 64'h100);
        do_cmd(C_STEP, '0, "step_on_flag");
        do_cmd(C_FLAG, '0, "flag_clear");
        check("flag_clr", flag_map, 64'h0);

        // Single reveal with one-cycle latency
        do_cmd(C_LOAD, 64'h1, "rev_load");
        do_cmd(C_RIGHT, '0, "rev_right");
        drive(C_STEP, '0);
        check("rev_step_lat", step_map, 64'h2);
        check("rev_busy", 64'(busy), 64'(0));
        model_apply(C_STEP, '0);
        settle_and_check("rev");

        // Loss: game_over with the mined cell's reveal, then everything frozen
        do_cmd(C_LOAD, 64'h1, "loss_load");
        drive(C_STEP, '0);
        check("loss_step_lat", step_map, 64'h1);
        check("loss_over_lat", 64'(game_over), 64'(1));
        model_apply(C_STEP, '0);
        settle_and_check("loss");
        do_cmd(C_RIGHT, '0, "loss_move");
        do_cmd(C_FLAG, '0, "loss_flag");
        do_cmd(C_DOWN | C_STEP, '0, "loss_step");
        do_cmd(C_LOAD, 64'h0, "loss_reload");

        // Flood and win from the far corner mine
        do_cmd(C_LOAD, 64'h8000_0000_0000_0000, "flood_load");
        drive(C_STEP, '0);
        model_apply(C_STEP, '0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 4096) begin
            cyc++;
            @(negedge clk);
        end
`ifdef MINE_LOGIC_FLOOD_FILL_EN
        check("flood_busy_len", 64'(cyc), 64'(128));
        check("flood_map", step_map, 64'h7FFF_FFFF_FFFF_FFFF);
        check("flood_won_early", 64'(game_won), 64'(0));
        @(negedge clk);
        check("flood_won", 64'(game_won), 64'(1));
`else
        check("flood_busy_len", 64'(cyc), 64'(0));
        check("flood_map", step_map, 64'h1);
        @(negedge clk);
        check("flood_won", 64'(game_won), 64'(0));
`endif
        compare_all("flood");

`ifdef MINE_LOGIC_FLOOD_FILL_EN
        // Load aborts a scan in progress
        do_cmd(C_LOAD, 64'h8000_0000_0000_0000, "abort_load");
        drive(C_STEP, '0);
        repeat (8) @(negedge clk);
        check("abort_busy_mid", 64'(busy), 64'(1));
        drive(C_LOAD, 64'h0);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_step", step_map, 64'h0);
        check("abort_mine", mine_map_q, 64'h0);
        model_apply(C_LOAD, 64'h0);
        settle_and_check("abort");
`endif

        // Random play, including simultaneous pulses to exercise priority
        for (int g = 0; g < 30; g++) begin
            do_cmd(C_LOAD, rand_map(), "rnd_load");
            for (int k = 0; k < 25; k++) begin
                case ($urandom_range(0, 11))
                    0:       cmd = C_LOAD;
                    1, 2, 3: cmd = C_STEP;
                    4:       cmd = C_FLAG;
                    5, 6:    cmd = C_UP;
                    7:       cmd = C_DOWN;
                    8:       cmd = C_LEFT;
                    default: cmd = C_RIGHT;
                endcase
                if ($urandom_range(0, 3) == 0)
                    cmd = cmd | (7'($urandom) & 7'b0111111);
                do_cmd(cmd, rand_map(), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mine_logic.md
# mine_logic

Game-state engine for the 8x8 minesweeper board. It owns the cursor, the flag map and the revealed (step) map, and applies player commands against a latched mine map. It performs optional flood-reveal of zero-count regions and detects win and loss. Its `flag_map`, `step_map` and latched `mine_map_q` outputs drive the gameboard renderer's `flagMap`, `stepMap` and `mineMap` inputs directly.

## Interface
- No parameters; board fixed at 8x8, cell index i = row*8 + col, bit i of every 64-bit map.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  synchronous, active-high reset.
- `mine_map`  in  64  mine layout, sampled only on `load`.
- `load`  in  1  pulse: latch `mine_map`, clear flags/steps/status, cursor to 0.
- `step`  in  1  pulse: reveal cell under cursor.
- `flag`  in  1  pulse: toggle flag under cursor.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  cursor move pulses.
- `mine_map_q`  out  64  latched mine layout.
- `flag_map`  out  64  flagged cells.
- `step_map`  out  64  revealed cells.
- `cursor`  out  6  {row[2:0], col[2:0]}.
- `busy`  out  1  flood scan in progress; commands other than `load` ignored.
- `game_over`  out  1  a mine was stepped on.
- `game_won`  out  1  every non-mine cell revealed.

## Operation
- Reset: all 64-bit outputs 0, `cursor`=0, `busy`=0, `game_over`=0, `game_won`=0, FSM in IDLE.
- Command priority when several pulses share a cycle: `load` > `step` > `flag` > `mv_up` > `mv_down` > `mv_left` > `mv_right`; only the highest is applied.
- `load` is accepted in any state, including mid-scan, where it aborts the scan and returns to IDLE.
- All other commands are ignored unless the FSM is in IDLE and `game_over`=`game_won`=0.
- Moves clamp at board edges; there is no wrap-around.
- `flag` toggles the cursor cell only if it is unrevealed; on a revealed cell it is ignored.
- `step` on a flagged or already-revealed cell is ignored. Otherwise it sets the cell's `step_map` bit, then:
  - Cell is a mine: `game_over`=1; the FSM enters LOST.
  - Cell has zero adjacent mines and FLOOD_FILL_EN is defined: enter SCAN.
  - Otherwise: stay in IDLE.
- Neighbour count is the number of the up-to-8 in-bounds neighbours set in `mine_map_q`, computed combinationally for the scan index, 4 bits wide.
- FSM states and transitions:
  - IDLE.
  - SCAN: 6-bit index `idx` runs 0..63, one cell per cycle, plus a `changed` flag. Cell `idx` is revealed if it is unrevealed, unflagged, not a mine, and has at least one revealed zero-count neighbour; revealing sets `changed`. At `idx`=63, if `changed`=1 the scan clears `changed` and restarts at 0; otherwise it returns to IDLE.
  - LOST and WON: terminal; left only via `load` or `reset`.
- Win check, in IDLE: if (`step_map` | `mine_map_q`) == all ones and `game_over`=0, set `game_won`=1 and enter WON.
- Flagging a mine is not required for a win.

## Timing
- Inputs are sampled on the rising edge of `clk`; every output is a register.
- Move, flag, step and load results are visible 1 cycle after the pulse.
- `game_over` rises in the same cycle the mined cell's `step_map` bit rises.
- `busy` rises in the cycle after the triggering step and stays high for exactly 64 × (number of passes) cycles. A reveal made during a pass is visible to later indices in the same pass.
- `game_won` rises 1 cycle after the FSM is in IDLE with the win condition true. This is 1 cycle after a non-flood step, or 1 cycle after `busy` falls.
- Pulses held longer than 1 cycle are treated as repeated commands; upstream must supply single-cycle pulses.

## Configuration
- `MINE_LOGIC_FLOOD_FILL_EN`.
  - Defined: SCAN state and flood reveal are compiled in.
  - Undefined: there is no SCAN state; `busy` is tied to 0; a step reveals exactly one cell. All other behaviour is unchanged.

## Test plan
- Reset: assert `reset` 2 cycles → all maps 0, `cursor`=0, `busy`/`game_over`/`game_won`=0.
- Moves and flags: `load` with `mine_map`=64'h1, `mv_right`, `mv_down`, `mv_left`, `mv_left` → `cursor`=6'o10 (the second left clamps at the edge); `flag` → `flag_map`=64'h100; `step` is ignored; second `flag` → `flag_map`=0.
- Single reveal: `mine_map`=64'h1, cursor 1, `step` → `step_map`=64'h2 next cycle (count 1, so no scan); `busy` stays 0.
- Loss: `mine_map`=64'h1, cursor 0, `step` → `step_map`=64'h1 and `game_over`=1; later `step`/`flag`/moves change nothing; `load` clears everything.
- Flood and win (macro defined): `mine_map`=64'h8000_0000_0000_0000, cursor 0, `step` → `busy` high exactly 128 cycles, `step_map`=64'h7FFF_FFFF_FFFF_FFFF, `game_won`=1 one cycle after `busy` falls.
- Load mid-scan, and macro undefined: `load` at scan cycle 10 → `busy`=0 and all maps cleared next cycle. With the macro undefined, the flood scenario gives `step_map`=64'h1, `busy` never high, `game_won`=0.
